// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: N_CH channels share one internal tri-state bus.
// A round-robin arbiter drives registered one-hot enables. Bursts are bounded,
// and a one-cycle turnaround (bus floats) separates any two owners.
module tristate_bus_arbiter #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8,
    parameter int SEL_W     = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH*DATA_W-1:0]   din,
    output logic [N_CH-1:0]          grant,
    output logic [SEL_W-1:0]         owner,
    output logic [DATA_W-1:0]        dout,
    output logic                     dout_valid,
    output logic                     bus_float,
    output logic                     contention
);

    // Width 1 is kept for MAX_BURST=1 so the counter is never zero-width.
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t             state, state_nx;
    logic [N_CH-1:0]    grant_nx;
    logic [SEL_W-1:0]   owner_nx;
    logic [SEL_W-1:0]   last, last_nx;
    logic [CNT_W-1:0]   burst_cnt, cnt_nx;
    logic               win_found;
    logic [SEL_W-1:0]   win;
    logic               others;

    tri   [DATA_W-1:0]  bus;
    logic [DATA_W-1:0]  bus_clean;

    // Per-channel tri-state driver: the channel drives the bus only while granted.
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_drv
        assign bus = grant[ch] ? din[ch*DATA_W +: DATA_W] : {DATA_W{1'bz}};
    end

    // Undriven (z) or unknown bits read as 0 before registering.
    for (genvar b = 0; b < DATA_W; b++) begin : g_clean
        assign bus_clean[b] = (bus[b] === 1'b1);
    end

    // Round-robin search: first requester after the last winner, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win       = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = (int'(last) + k) % N_CH;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win       = SEL_W'(idx);
            end
        end
    end

    // Any request from a channel other than the current owner.
    assign others = |(req & ~grant);

    // FSM state and arbitration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            owner     <= '0;
            last      <= SEL_W'(N_CH - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            owner     <= owner_nx;
            last      <= last_nx;
            burst_cnt <= cnt_nx;
        end
    end

    // Next-state logic: arbitrate from IDLE/TURN, bound the burst in OWN.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        owner_nx = owner;
        last_nx  = last;
        cnt_nx   = burst_cnt;
        case (state)
            IDLE, TURN: begin
                grant_nx = '0;
                state_nx = IDLE;
                if (win_found) begin
                    state_nx      = OWN;
                    grant_nx[win] = 1'b1;
                    owner_nx      = win;
                    last_nx       = win;
                    cnt_nx        = '0;
                end
            end
            OWN: begin
                if (!req[owner] || (burst_cnt == CNT_MAX && others)) begin
                    state_nx = TURN;
                    grant_nx = '0;
                end else if (burst_cnt != CNT_MAX) begin
                    cnt_nx = burst_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    // Register the bus value one cycle after it is driven; flag multi-grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            bus_float  <= 1'b1;
            contention <= 1'b0;
        end else begin
            dout       <= bus_clean;
            dout_valid <= |grant;
            bus_float  <= ~|grant;
            contention <= contention | ((grant & (grant - N_CH'(1))) != '0);
        end
    end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench: stimulus pushes expected per-cycle observations from a
// cycle-level ownership model; a monitor pops and compares after each edge.
module tb_tristate_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 8;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] din = '0;
    logic [N-1:0]   grant;
    logic [SW-1:0]  owner;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic           bus_float;
    logic           contention;

    tristate_bus_arbiter #(.N_CH(N), .DATA_W(W), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din),
        .grant(grant), .owner(owner), .dout(dout), .dout_valid(dout_valid),
        .bus_float(bus_float), .contention(contention)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  grant;
        logic [SW-1:0] owner;
        logic [W-1:0]  dout;
        logic          valid;
        logic          flt;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   tests = 0;
    int   fails = 0;
    bit   stim_done = 1'b0;

    // Model: current owner (-1 = bus floating), cycles owned so far, RR pointer.
    int m_own = -1;
    int m_run = 0;
    int m_last = N - 1;
    int m_owner_out = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, record what the DUT must show after the next edge.
    task automatic step(input bit rst, input logic [N-1:0] r, input logic [N*W-1:0] d);
        exp_t e;
        bool_others: begin end
        @(negedge clk);
        reset = rst;
        req   = r;
        din   = d;
        if (rst) begin
            e.dout = '0; e.valid = 1'b0; e.flt = 1'b1;
            m_own = -1; m_run = 0; m_last = N - 1; m_owner_out = 0;
        end else begin
            if (m_own >= 0) begin
                e.dout = d[m_own*W +: W]; e.valid = 1'b1; e.flt = 1'b0;
                m_run++;
                if (!r[m_own] || (m_run >= MB && (r & ~(N'(1) << m_own)) != '0))
                    m_own = -1;
            end else begin
                bit found;
                found = 1'b0;
                e.dout = '0; e.valid = 1'b0; e.flt = 1'b1;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (!found && r[c]) begin
                        found = 1'b1;
                        m_own = c; m_last = c; m_owner_out = c; m_run = 0;
                    end
                end
            end
        end
        e.grant = (m_own >= 0) ? (N'(1) << m_own) : '0;
        e.owner = SW'(m_owner_out);
        q.push_back(e);
    endtask

    // Monitor: compare each registered output just after the clock edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            e_m = q.pop_front();
            chk("grant", 32'(grant), 32'(e_m.grant));
            chk("owner", 32'(owner), 32'(e_m.owner));
            chk("dout", 32'(dout), 32'(e_m.dout));
            chk("dout_valid", 32'(dout_valid), 32'(e_m.valid));
            chk("bus_float", 32'(bus_float), 32'(e_m.flt));
        end
        chk("grant_onehot0", 32'($countones(grant) <= 1), 32'd1);
        chk("contention", 32'(contention), 32'd0);
    end

    // Stimulus: directed scenarios, then randomized traffic with rare resets.
    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   r;
        bit             rs;
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        repeat (10) step(1'b0, '0, '0);
        d = '0;
        d[2*W +: W] = 8'hA5;
        repeat (20) step(1'b0, 4'b0100, d);
        step(1'b1, '0, d);
        for (int i = 0; i < N; i++) d[i*W +: W] = W'(i + 1);
        repeat (40) step(1'b0, 4'b1111, d);
        step(1'b1, '0, d);
        repeat (3) step(1'b0, 4'b0010, d);
        repeat (2) step(1'b0, 4'b1010, d);
        repeat (4) step(1'b0, 4'b1000, d);
        repeat (4) step(1'b0, 4'b0100, d);
        step(1'b1, 4'b1111, d);
        repeat (12) step(1'b0, 4'b1111, d);
        r = N'($urandom);
        repeat (10000) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) r[b] = ~r[b];
            d  = N*W'($urandom);
            rs = ($urandom_range(999) == 0);
            step(rs, r, d);
        end
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        stim_done = 1'b1;
    end

    // Drain the scoreboard and report.
    initial begin
        wait (stim_done);
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
